// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and byte-level helpers
// Used by both the iterative encrypt engine and the decrypt side.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } aes_fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Byte 0 of a word sits in bits [31:24], matching the block byte order.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [AES_NR-1:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        unique case (rnd)
            10'b0000000001: r = 8'h01;
            10'b0000000010: r = 8'h02;
            10'b0000000100: r = 8'h04;
            10'b0000001000: r = 8'h08;
            10'b0000010000: r = 8'h10;
            10'b0000100000: r = 8'h20;
            10'b0001000000: r = 8'h40;
            10'b0010000000: r = 8'h80;
            10'b0100000000: r = 8'h1b;
            10'b1000000000: r = 8'h36;
            default:        r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// rtl/aes_enc_round.sv - one combinational AES encryption round plus forward key step
// Final round (rnd[9]) skips MixColumns.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic [9:0]   i_rnd,
    output logic [127:0] o_state,
    output logic [127:0] o_rk
);

    logic [31:0]  w_sb [4];
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [31:0]  w_kt;
    logic [31:0]  w_nk0, w_nk1, w_nk2, w_nk3;
    logic [127:0] w_nk;

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_sb[c] = sub_word(i_state[127-32*c -: 32]);
        assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    end

    // Output byte 4c+r takes row r from column (c+r) mod 4.
    for (genvar k = 0; k < 16; k++) begin : g_sr
        localparam int SRC = (k + 4 * (k % 4)) % 16;
        assign w_sr[127-8*k -: 8] = w_sb[SRC/4][31-8*(SRC%4) -: 8];
    end

    assign w_kt  = sub_word({i_rk[23:0], i_rk[31:24]}) ^ {rcon(i_rnd), 24'h000000};
    assign w_nk0 = i_rk[127:96] ^ w_kt;
    assign w_nk1 = i_rk[95:64]  ^ w_nk0;
    assign w_nk2 = i_rk[63:32]  ^ w_nk1;
    assign w_nk3 = i_rk[31:0]   ^ w_nk2;
    assign w_nk  = {w_nk0, w_nk1, w_nk2, w_nk3};

    assign o_rk    = w_nk;
    assign o_state = (i_rnd[AES_NR-1] ? w_sr : w_mc) ^ w_nk;

endmodule

// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128 encrypt engine, one round per clock
// Define AES_ENC_LASTKEY_EN to expose the round-10 key on kout.
module aes_enc_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
`ifdef AES_ENC_LASTKEY_EN
    ,
    output logic [127:0] kout
`endif
);

    aes_fsm_t              r_fsm;
    logic [AES_BLK_W-1:0]  r_state;
    logic [AES_BLK_W-1:0]  r_rk;
    logic [AES_NR-1:0]     r_rnd;
    logic [AES_BLK_W-1:0]  r_dout;
    logic [AES_BLK_W-1:0]  w_nstate;
    logic [AES_BLK_W-1:0]  w_nrk;
`ifdef AES_ENC_LASTKEY_EN
    logic [AES_BLK_W-1:0]  r_kout;
`endif

    aes_enc_round u_round (
        .i_state (r_state),
        .i_rk    (r_rk),
        .i_rnd   (r_rnd),
        .o_state (w_nstate),
        .o_rk    (w_nrk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= FSM_IDLE;
            r_state <= '0;
            r_rk    <= '0;
            r_rnd   <= '0;
            r_dout  <= '0;
`ifdef AES_ENC_LASTKEY_EN
            r_kout  <= '0;
`endif
        end else begin
            case (r_fsm)
                FSM_IDLE: begin
                    if (in_valid) begin
                        r_state <= din ^ key;
                        r_rk    <= key;
                        r_rnd   <= 10'b0000000001;
                        r_fsm   <= FSM_RUN;
                    end
                end
                FSM_RUN: begin
                    r_state <= w_nstate;
                    r_rk    <= w_nrk;
                    r_rnd   <= r_rnd << 1;
                    if (r_rnd[AES_NR-1]) begin
                        r_dout <= w_nstate;
`ifdef AES_ENC_LASTKEY_EN
                        r_kout <= w_nrk;
`endif
                        r_fsm  <= FSM_DONE;
                    end
                end
                FSM_DONE: begin
                    // The working key is wiped on exit so only kout can retain it.
                    if (out_ready) begin
                        r_rk  <= '0;
                        r_fsm <= FSM_IDLE;
                    end
                end
                default: r_fsm <= FSM_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == FSM_IDLE);
    assign out_valid = (r_fsm == FSM_DONE);
    assign dout      = r_dout;
`ifdef AES_ENC_LASTKEY_EN
    assign kout      = r_kout;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - self-checking bench for aes_enc_iter against a matrix-level AES model
module tb_aes_enc_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] dout;
`ifdef AES_ENC_LASTKEY_EN
    logic [127:0] kout;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] L1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] L2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [7:0] sb [256];

    aes_enc_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
`ifdef AES_ENC_LASTKEY_EN
        ,
        .kout      (kout)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_model(input logic [127:0] pt, input logic [127:0] k,
                             output logic [127:0] ct, output logic [127:0] lk);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [4][4];
        logic [7:0]  m [4][4];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32*i));
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = 8'(pt >> (120 - 8*(4*c + r))) ^ 8'(w[c] >> (24 - 8*r));
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m[r][c] = sb[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd < 10)
                        s[r][c] = gmul(8'h02, m[r][c]) ^ gmul(8'h03, m[(r+1)%4][c])
                                ^ m[(r+2)%4][c] ^ m[(r+3)%4][c];
                    else
                        s[r][c] = m[r][c];
                    s[r][c] = s[r][c] ^ 8'(w[4*rd + c] >> (24 - 8*r));
                end
        end
        ct = '0;
        for (int n = 0; n < 16; n++) ct = (ct << 8) | 128'(s[n % 4][n / 4]);
        lk = {w[40], w[41], w[42], w[43]};
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] k, output bit ok);
        ok = 1'b0;
        din = pt;
        key = k;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++;
        if (dout !== 128'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
`ifdef AES_ENC_LASTKEY_EN
        n_vec++;
        if (kout !== 128'h0) begin n_err++; $display("FAIL reset_kout: got %h want 0", kout); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        logic [127:0] pt [2];
        logic [127:0] k [2];
        logic [127:0] ec [2];
        logic [127:0] el [2];
        bit ok;
        int lat;
        pt = '{P1, P2}; k = '{K1, K2}; ec = '{C1, C2}; el = '{L1, L2};
        for (int v = 0; v < 2; v++) begin
            send(pt[v], k[v], ok);
            n_vec++;
            if (!ok) begin n_err++; $display("FAIL fips%0d_accept: got timeout want accept", v); end
            wait_out(lat);
            n_vec++;
            if (lat !== 10) begin n_err++; $display("FAIL fips%0d_latency: got %0d want 10", v, lat); end
            n_vec++;
            if (dout !== ec[v]) begin n_err++; $display("FAIL fips%0d_dout: got %h want %h", v, dout, ec[v]); end
`ifdef AES_ENC_LASTKEY_EN
            n_vec++;
            if (kout !== el[v]) begin n_err++; $display("FAIL fips%0d_kout: got %h want %h", v, kout, el[v]); end
`endif
            take();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL fips%0d_release: got valid=%b ready=%b want valid=0 ready=1", v, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        int bad;
        send(P1, K1, ok);
        wait_out(lat);
        n_vec++;
        if (!ok || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_start: got valid=%b want 1", out_valid); end
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            if (dout !== C1 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        take();
        repeat (3) begin
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_single: got valid=%b want 0", out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_c [8];
        int acc [8];
        int b, o, cyc;
        b = 0; o = 0; cyc = 0;
        out_ready = 1'b1;
        while (o < 8 && cyc < 300) begin
            if (out_valid) begin
                n_vec++;
                if (dout !== exp_c[o]) begin n_err++; $display("FAIL b2b_dout%0d: got %h want %h", o, dout, exp_c[o]); end
                o++;
            end
            if (in_ready && b < 8) begin
                din = (b % 2 == 0) ? P1 : P2;
                key = (b % 2 == 0) ? K1 : K2;
                exp_c[b] = (b % 2 == 0) ? C1 : C2;
                acc[b] = cyc;
                in_valid = 1'b1;
                b++;
            end else begin
                din = {$urandom, $urandom, $urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
                in_valid = (b < 8);
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (o !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", o); end
        for (int i = 1; i < b; i++) begin
            n_vec++;
            if (acc[i] - acc[i-1] !== 12) begin
                n_err++;
                $display("FAIL b2b_spacing%0d: got %0d want 12", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, k, ec, el;
        bit ok;
        int lat;
        for (int i = 0; i < 12; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            aes_model(pt, k, ec, el);
            send(pt, k, ok);
            wait_out(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_vec++;
            if (!ok || dout !== ec) begin n_err++; $display("FAIL rand%0d_dout: got %h want %h", i, dout, ec); end
`ifdef AES_ENC_LASTKEY_EN
            n_vec++;
            if (kout !== el) begin n_err++; $display("FAIL rand%0d_kout: got %h want %h", i, kout, el); end
`endif
            take();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        send(P1, K1, ok);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_hs: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        n_vec++;
        if (dout !== 128'h0) begin n_err++; $display("FAIL midrst_dout: got %h want 0", dout); end
`ifdef AES_ENC_LASTKEY_EN
        n_vec++;
        if (kout !== 128'h0) begin n_err++; $display("FAIL midrst_kout: got %h want 0", kout); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        @(negedge clk);
        repeat (12) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_partial: got valid=%b want 0", out_valid); end
        send(P2, K2, ok);
        wait_out(lat);
        n_vec++;
        if (!ok || lat !== 10 || dout !== C2) begin
            n_err++;
            $display("FAIL midrst_vec2: got %h lat %0d want %h lat 10", dout, lat, C2);
        end
        take();
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
